mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch and data access share one
// memory port. One transaction at a time; data has priority except when
// fetch has been passed over twice in a row. A WAIT timeout forces an
// error response so a silent memory cannot hang either requester.
module mem_arbiter #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,        // active-high despite the name

  input  logic            i_req,
  input  logic [XLEN-1:0] i_adr,
  output logic [XLEN-1:0] i_resp,
  output logic            i_resp_v,
  output logic            i_resp_error,

  input  logic            d_r_v,
  input  logic            d_w_v,
  input  logic [XLEN-1:0] d_adr,
  input  logic [XLEN-1:0] d_data,
  input  logic [3:0]      d_strobe,
  output logic [XLEN-1:0] d_resp,
  output logic            d_resp_v,
  output logic            d_resp_error,

  output logic            m_r_v,
  output logic            m_w_v,
  output logic [XLEN-1:0] m_adr,
  output logic [XLEN-1:0] m_data,
  output logic [3:0]      m_strobe,
  input  logic [XLEN-1:0] m_resp,
  input  logic            m_resp_v,
  input  logic            m_resp_error,

  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int unsigned    CW       = $clog2(TIMEOUT + 1);
  // wait_cnt is 0 in the first WAIT cycle, so the last allowed cycle is TIMEOUT-1
  localparam logic [CW-1:0]  TMO_LAST = CW'(TIMEOUT - 1);

  state_t          state;
  state_t          state_nx;

  logic [1:0]      starve;
  logic [CW-1:0]   wait_cnt;

  logic [XLEN-1:0] lat_adr;
  logic [XLEN-1:0] lat_data;
  logic [3:0]      lat_strobe;
  logic            lat_we;
  logic            lat_port;     // 1 = data port, 0 = fetch port

  logic [XLEN-1:0] resp_word;
  logic            resp_err;

  logic            data_req;
  logic            data_bad;
  logic            take;
  logic            grant_fetch;
  logic            tmo_hit;

  assign data_req    = d_r_v | d_w_v;
  assign data_bad    = d_r_v & d_w_v;
  assign take        = (state == IDLE) & (i_req | data_req);
  assign grant_fetch = i_req & (~data_req | (starve == 2'd2));
  assign tmo_hit     = (wait_cnt == TMO_LAST);

  assign m_adr        = lat_adr;
  assign m_data       = lat_data;
  assign m_strobe     = lat_strobe;
  assign i_resp       = resp_word;
  assign i_resp_error = resp_err;
  assign d_resp       = resp_word;
  assign d_resp_error = resp_err;

  // State register
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state and strobe/valid decode
  always_comb begin
    state_nx = state;
    m_r_v    = 1'b0;
    m_w_v    = 1'b0;
    i_resp_v = 1'b0;
    d_resp_v = 1'b0;
    busy     = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (take) begin
          // a data request with both directions set bypasses memory entirely
          state_nx = (!grant_fetch && data_bad) ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        m_r_v    = ~lat_we;
        m_w_v    = lat_we;
        state_nx = WAIT;
      end
      WAIT: begin
        if (m_resp_v || tmo_hit) state_nx = RESP;
      end
      RESP: begin
        i_resp_v = ~lat_port;
        d_resp_v = lat_port;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Starvation counter: counts consecutive data grants that bypassed a pending fetch
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      starve <= '0;
    end else if (take) begin
      if (grant_fetch)                    starve <= '0;
      else if (i_req && starve != 2'd2)   starve <= starve + 2'd1;
    end
  end

  // WAIT cycle counter, zero outside WAIT
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)              wait_cnt <= '0;
    else if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
    else                    wait_cnt <= '0;
  end

  // Latch the winning request in IDLE
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      lat_adr    <= '0;
      lat_data   <= '0;
      lat_strobe <= '0;
      lat_we     <= 1'b0;
      lat_port   <= 1'b0;
    end else if (take) begin
      lat_port <= ~grant_fetch;
      if (grant_fetch) begin
        lat_adr    <= i_adr;
        lat_data   <= '0;
        lat_strobe <= '1;
        lat_we     <= 1'b0;
      end else begin
        lat_adr    <= d_adr;
        lat_data   <= d_data;
        lat_strobe <= d_strobe;
        lat_we     <= d_w_v;
      end
    end
  end

  // Capture the response word: memory reply, forced timeout error, or illegal-request error
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      resp_word <= '0;
      resp_err  <= 1'b0;
    end else if (take && !grant_fetch && data_bad) begin
      resp_word <= '0;
      resp_err  <= 1'b1;
    end else if (state == WAIT) begin
      // memory reply wins when it lands on the timeout cycle
      if (m_resp_v) begin
        resp_word <= m_resp;
        resp_err  <= m_resp_error;
      end else if (tmo_hit) begin
        resp_word <= '0;
        resp_err  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, write, contention ordering,
// timeout and its boundary, illegal data request, stray memory replies
// and asynchronous reset in the middle of a transaction.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req;
  logic [31:0] i_adr;
  logic [31:0] i_resp;
  logic        i_resp_v;
  logic        i_resp_error;
  logic        d_r_v;
  logic        d_w_v;
  logic [31:0] d_adr;
  logic [31:0] d_data;
  logic [3:0]  d_strobe;
  logic [31:0] d_resp;
  logic        d_resp_v;
  logic        d_resp_error;
  logic        m_r_v;
  logic        m_w_v;
  logic [31:0] m_adr;
  logic [31:0] m_data;
  logic [3:0]  m_strobe;
  logic [31:0] m_resp;
  logic        m_resp_v;
  logic        m_resp_error;
  logic        busy;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  mem_arbiter #(.XLEN(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_adr(i_adr), .i_resp(i_resp), .i_resp_v(i_resp_v),
    .i_resp_error(i_resp_error),
    .d_r_v(d_r_v), .d_w_v(d_w_v), .d_adr(d_adr), .d_data(d_data),
    .d_strobe(d_strobe), .d_resp(d_resp), .d_resp_v(d_resp_v),
    .d_resp_error(d_resp_error),
    .m_r_v(m_r_v), .m_w_v(m_w_v), .m_adr(m_adr), .m_data(m_data),
    .m_strobe(m_strobe), .m_resp(m_resp), .m_resp_v(m_resp_v),
    .m_resp_error(m_resp_error),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; i_req = 1'b0; i_adr = '0; d_r_v = 1'b0; d_w_v = 1'b0;
    d_adr = '0; d_data = '0; d_strobe = '0; m_resp = '0; m_resp_v = 1'b0;
    m_resp_error = 1'b0;
    #3;
    vectors++; if ({busy, m_r_v, m_w_v, i_resp_v, d_resp_v} !== 5'b0) begin miscompares++;
      $display("FAIL reset_ctrl: got %b expected 00000", {busy, m_r_v, m_w_v, i_resp_v, d_resp_v}); end
    vectors++; if ({m_adr, m_data, i_resp, d_resp} !== 128'h0) begin miscompares++;
      $display("FAIL reset_data: got %h expected 0", {m_adr, m_data, i_resp, d_resp}); end
    // requests during reset must not be taken
    i_req = 1'b1; i_adr = 32'h44;
    tick(); tick();
    vectors++; if ({busy, m_r_v} !== 2'b00) begin miscompares++;
      $display("FAIL reset_hold: got %b expected 00", {busy, m_r_v}); end
    i_req = 1'b0;
    rst_n = 1'b0;
    tick();
    vectors++; if (busy !== 1'b0) begin miscompares++;
      $display("FAIL reset_release_idle: got %b expected 0", busy); end
  endtask

  task automatic test_fetch();
    i_req = 1'b1; i_adr = 32'h0001_0004;
    tick();
    vectors++; if ({m_r_v, m_w_v, busy} !== 3'b101) begin miscompares++;
      $display("FAIL fetch_issue: got %b expected 101", {m_r_v, m_w_v, busy}); end
    vectors++; if (m_adr !== 32'h0001_0004) begin miscompares++;
      $display("FAIL fetch_adr: got %h expected 00010004", m_adr); end
    tick();
    vectors++; if ({m_r_v, m_adr} !== {1'b0, 32'h0001_0004}) begin miscompares++;
      $display("FAIL fetch_wait1: got %b/%h expected 0/00010004", m_r_v, m_adr); end
    tick();
    m_resp = 32'hDEAD_BEEF; m_resp_v = 1'b1;
    vectors++; if (i_resp_v !== 1'b0) begin miscompares++;
      $display("FAIL fetch_early_resp: got %b expected 0", i_resp_v); end
    tick();
    m_resp_v = 1'b0;
    vectors++; if ({i_resp_v, d_resp_v, i_resp_error} !== 3'b100) begin miscompares++;
      $display("FAIL fetch_resp_v: got %b expected 100", {i_resp_v, d_resp_v, i_resp_error}); end
    vectors++; if (i_resp !== 32'hDEAD_BEEF) begin miscompares++;
      $display("FAIL fetch_resp: got %h expected deadbeef", i_resp); end
    i_req = 1'b0;
    tick();
    vectors++; if ({i_resp_v, busy} !== 2'b00) begin miscompares++;
      $display("FAIL fetch_done: got %b expected 00", {i_resp_v, busy}); end
  endtask

  task automatic test_write();
    d_w_v = 1'b1; d_adr = 32'h0002_0010; d_data = 32'h1234_5678; d_strobe = 4'hF;
    tick();
    vectors++; if ({m_w_v, m_r_v} !== 2'b10) begin miscompares++;
      $display("FAIL write_issue: got %b expected 10", {m_w_v, m_r_v}); end
    vectors++; if ({m_adr, m_data, m_strobe} !== {32'h0002_0010, 32'h1234_5678, 4'hF}) begin
      miscompares++;
      $display("FAIL write_bus: got %h %h %h expected 00020010 12345678 f", m_adr, m_data, m_strobe); end
    tick();
    vectors++; if ({m_w_v, m_data} !== {1'b0, 32'h1234_5678}) begin miscompares++;
      $display("FAIL write_wait: got %b/%h expected 0/12345678", m_w_v, m_data); end
    m_resp = 32'hCAFE_0001; m_resp_v = 1'b1;
    tick();
    m_resp_v = 1'b0;
    vectors++; if ({d_resp_v, i_resp_v, d_resp_error, d_resp} !== {3'b100, 32'hCAFE_0001}) begin
      miscompares++;
      $display("FAIL write_resp: got %b%b%b %h expected 100 cafe0001", d_resp_v, i_resp_v, d_resp_error, d_resp); end
    d_w_v = 1'b0;
    tick();
    vectors++; if ({d_resp_v, busy} !== 2'b00) begin miscompares++;
      $display("FAIL write_done: got %b expected 00", {d_resp_v, busy}); end
  endtask

  task automatic test_back_to_back();
    logic fetch_exp;
    logic [31:0] adr_exp;
    i_req = 1'b1; i_adr = 32'h100; d_r_v = 1'b1; d_adr = 32'h200;
    for (int k = 0; k < 6; k++) begin
      fetch_exp = ((k % 3) == 2);
      adr_exp   = fetch_exp ? 32'h100 : 32'h200;
      tick();
      vectors++; if ({m_r_v, m_adr} !== {1'b1, adr_exp}) begin miscompares++;
        $display("FAIL grant_%0d: got %b/%h expected 1/%h", k, m_r_v, m_adr, adr_exp); end
      tick();
      m_resp = 32'h1000 + 32'(k); m_resp_v = 1'b1;
      tick();
      m_resp_v = 1'b0;
      vectors++; if ({i_resp_v, d_resp_v, i_resp} !== {fetch_exp, ~fetch_exp, 32'h1000 + 32'(k)}) begin
        miscompares++;
        $display("FAIL grant_resp_%0d: got %b%b %h expected %b%b %h", k, i_resp_v, d_resp_v,
                 i_resp, fetch_exp, ~fetch_exp, 32'h1000 + 32'(k)); end
      if (k == 5) begin i_req = 1'b0; d_r_v = 1'b0; end
      tick();
    end
    vectors++; if (busy !== 1'b0) begin miscompares++;
      $display("FAIL b2b_idle: got %b expected 0", busy); end
  endtask

  task automatic test_timeout(input logic late_reply);
    d_r_v = 1'b1; d_adr = 32'h300; m_resp = 32'h5555_5555; m_resp_error = 1'b0;
    tick();
    tick();                       // first WAIT cycle
    for (int c = 2; c <= 15; c++) begin
      tick();                     // WAIT cycle c
      vectors++; if ({d_resp_v, busy} !== 2'b01) begin miscompares++;
        $display("FAIL timeout_wait_%0d: got %b expected 01", c, {d_resp_v, busy}); end
    end
    if (late_reply) begin m_resp = 32'hA5A5_0F0F; m_resp_v = 1'b1; end
    tick();
    m_resp_v = 1'b0;
    if (late_reply) begin
      vectors++; if ({d_resp_v, d_resp_error, d_resp} !== {2'b10, 32'hA5A5_0F0F}) begin miscompares++;
        $display("FAIL timeout_edge: got %b%b %h expected 10 a5a50f0f", d_resp_v, d_resp_error, d_resp); end
    end else begin
      vectors++; if ({d_resp_v, d_resp_error, d_resp} !== {2'b11, 32'h0}) begin miscompares++;
        $display("FAIL timeout_err: got %b%b %h expected 11 00000000", d_resp_v, d_resp_error, d_resp); end
    end
    d_r_v = 1'b0;
    tick();
    vectors++; if ({d_resp_v, busy} !== 2'b00) begin miscompares++;
      $display("FAIL timeout_done: got %b expected 00", {d_resp_v, busy}); end
  endtask

  task automatic test_illegal();
    d_r_v = 1'b1; d_w_v = 1'b1; d_adr = 32'h400; d_data = 32'hFFFF_FFFF;
    tick();
    vectors++; if ({m_r_v, m_w_v} !== 2'b00) begin miscompares++;
      $display("FAIL illegal_no_mem: got %b expected 00", {m_r_v, m_w_v}); end
    vectors++; if ({d_resp_v, i_resp_v, d_resp_error, d_resp} !== {3'b101, 32'h0}) begin miscompares++;
      $display("FAIL illegal_resp: got %b%b%b %h expected 101 00000000", d_resp_v, i_resp_v,
               d_resp_error, d_resp); end
    d_r_v = 1'b0; d_w_v = 1'b0;
    tick();
    vectors++; if ({m_r_v, m_w_v, d_resp_v, busy} !== 4'b0) begin miscompares++;
      $display("FAIL illegal_done: got %b expected 0000", {m_r_v, m_w_v, d_resp_v, busy}); end
  endtask

  task automatic test_stray_resp();
    m_resp = 32'h1111_1111; m_resp_v = 1'b1;
    tick();
    vectors++; if ({busy, i_resp_v, d_resp_v} !== 3'b000) begin miscompares++;
      $display("FAIL stray_idle: got %b expected 000", {busy, i_resp_v, d_resp_v}); end
    i_req = 1'b1; i_adr = 32'h500;
    tick();                        // ISSUE with m_resp_v still high
    tick();
    m_resp_v = 1'b0;
    vectors++; if ({busy, i_resp_v} !== 2'b10) begin miscompares++;
      $display("FAIL stray_issue: got %b expected 10", {busy, i_resp_v}); end
    m_resp = 32'h2222_2222; m_resp_v = 1'b1;
    tick();
    vectors++; if ({i_resp_v, i_resp} !== {1'b1, 32'h2222_2222}) begin miscompares++;
      $display("FAIL stray_resp: got %b %h expected 1 22222222", i_resp_v, i_resp); end
    i_req = 1'b0; m_resp = 32'h3333_3333;
    tick();
    m_resp_v = 1'b0;
    vectors++; if ({i_resp_v, busy} !== 2'b00) begin miscompares++;
      $display("FAIL stray_done: got %b expected 00", {i_resp_v, busy}); end
  endtask

  task automatic test_reset_in_wait();
    d_r_v = 1'b1; d_adr = 32'h600;
    tick();
    tick();                        // WAIT
    #2 rst_n = 1'b1;
    #1;
    vectors++; if ({busy, m_r_v, m_w_v, d_resp_v, i_resp_v} !== 5'b0) begin miscompares++;
      $display("FAIL rstwait_ctrl: got %b expected 00000", {busy, m_r_v, m_w_v, d_resp_v, i_resp_v}); end
    vectors++; if ({m_adr, d_resp, d_resp_error} !== 65'h0) begin miscompares++;
      $display("FAIL rstwait_data: got %h %h %b expected 0", m_adr, d_resp, d_resp_error); end
    d_r_v = 1'b0;
    tick();
    rst_n = 1'b0;
    m_resp = 32'h7777_7777; m_resp_v = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++; if ({busy, d_resp_v, i_resp_v} !== 3'b000) begin miscompares++;
        $display("FAIL rstwait_late_%0d: got %b expected 000", c, {busy, d_resp_v, i_resp_v}); end
    end
    m_resp_v = 1'b0;
    // first request after release is taken on the very next edge
    d_r_v = 1'b1; d_adr = 32'h700;
    tick();
    vectors++; if ({m_r_v, m_adr} !== {1'b1, 32'h700}) begin miscompares++;
      $display("FAIL rstwait_new_req: got %b/%h expected 1/00000700", m_r_v, m_adr); end
    tick();
    m_resp = 32'h8888_8888; m_resp_v = 1'b1;
    tick();
    m_resp_v = 1'b0;
    vectors++; if ({d_resp_v, d_resp} !== {1'b1, 32'h8888_8888}) begin miscompares++;
      $display("FAIL rstwait_new_resp: got %b %h expected 1 88888888", d_resp_v, d_resp); end
    d_r_v = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_write();
    test_back_to_back();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_illegal();
    test_stray_resp();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
